// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable frame format.
// Words are accepted over a ready/valid interface into an internal FIFO and
// serialised LSB-first as: start bit, data bits, optional parity bit, stop bit(s).
// A running 32-bit checksum of all transmitted words is kept for debug/LEDs.
//
// Ports:
//   clock       system clock
//   tock_reset  asynchronous, active-high reset
//   i_data      word to transmit
//   i_valid     i_data valid this cycle
//   o_ready     FIFO can accept a word (count < fifo_depth)
//   o_serial    serial line, idle high (registered)
//   o_busy      a frame is in progress (state != IDLE)
//   o_count     FIFO occupancy
//   o_checksum  running sum (mod 2^32) of every word popped for transmission
module uart_tx_fifo #(
  parameter int unsigned cycles_per_bit = 20000,
  parameter int unsigned data_bits      = 8,
  parameter int unsigned parity_mode    = 0,
  parameter int unsigned stop_bits      = 1,
  parameter int unsigned fifo_depth     = 16
) (
  input  logic                        clock,
  input  logic                        tock_reset,
  input  logic [data_bits-1:0]        i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_serial,
  output logic                        o_busy,
  output logic [$clog2(fifo_depth):0] o_count,
  output logic [31:0]                 o_checksum
);

  localparam int unsigned AW = $clog2(fifo_depth);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(cycles_per_bit);
  localparam int unsigned BW = 4;

  if (parity_mode > 2) begin : g_bad_parity
    $error("uart_tx_fifo: parity_mode must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (stop_bits < 1 || stop_bits > 2) begin : g_bad_stop
    $error("uart_tx_fifo: stop_bits must be 1 or 2");
  end
  if (data_bits < 5 || data_bits > 9) begin : g_bad_data
    $error("uart_tx_fifo: data_bits must be 5..9");
  end
  if (cycles_per_bit < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: cycles_per_bit must be at least 2");
  end
  if (fifo_depth < 2 || fifo_depth > 256 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: fifo_depth must be a power of two in 2..256");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [data_bits-1:0] mem [fifo_depth];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [data_bits-1:0] shift;
  logic                 par_bit;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_idx;
  logic [data_bits-1:0] head;
  logic                 tick_last;
  logic                 last_stop;
  logic                 push;
  logic                 pop;
  logic                 line;

  always_comb begin
    head      = mem[rd_ptr];
    o_ready   = (o_count < CW'(fifo_depth));
    push      = i_valid && o_ready;
    tick_last = (tick == TW'(cycles_per_bit - 1));
    last_stop = (state == STOP) && tick_last && (bit_idx == BW'(stop_bits - 1));
    // Popping in the final stop cycle gives zero-gap back-to-back frames.
    pop       = ((state == IDLE) || last_stop) && (o_count != '0);
    o_busy    = (state != IDLE);
  end

  // Line level for the current state; o_serial registers it, so the line
  // trails the state by one cycle (start bit appears the edge after the pop).
  always_comb begin
    line = 1'b1;
    case (state)
      START:   line = 1'b0;
      DATA:    line = shift[0];
      PARITY:  line = par_bit;
      default: line = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clock or posedge tock_reset) begin
    if (tock_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge tock_reset) begin
    if (tock_reset) begin
      state      <= IDLE;
      o_serial   <= 1'b1;
      o_checksum <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      tick       <= '0;
      bit_idx    <= '0;
    end else begin
      o_serial <= line;
      case (state)
        IDLE: begin
          if (pop) begin
            state <= START;
            tick  <= '0;
          end
        end
        START: begin
          if (tick_last) begin
            state   <= DATA;
            tick    <= '0;
            bit_idx <= '0;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tick_last) begin
            tick  <= '0;
            shift <= shift >> 1;
            if (bit_idx == BW'(data_bits - 1)) begin
              bit_idx <= '0;
              state   <= (parity_mode != 0) ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        PARITY: begin
          if (tick_last) begin
            state   <= STOP;
            tick    <= '0;
            bit_idx <= '0;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        STOP: begin
          if (tick_last) begin
            tick <= '0;
            if (bit_idx == BW'(stop_bits - 1)) begin
              bit_idx <= '0;
              state   <= pop ? START : IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (pop) begin
        shift      <= head;
        // Odd mode inverts the XOR so the ones-count including parity is odd.
        par_bit    <= (^head) ^ (parity_mode == 1);
        o_checksum <= o_checksum + 32'(head);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. Three instances with different frame
// formats; accepted words go into a per-instance scoreboard queue and a line
// monitor rebuilds each expected frame bit-by-bit from the popped word.
module tb_uart_tx_fifo;

  localparam int unsigned CPB_T [3] = '{4, 4, 2};
  localparam int unsigned DB_T  [3] = '{8, 7, 8};
  localparam int unsigned PM_T  [3] = '{0, 2, 1};
  localparam int unsigned SB_T  [3] = '{1, 2, 1};
  localparam int unsigned DEP_T [3] = '{4, 4, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  din  [3];
  logic        vld  [3];
  logic        rdy  [3];
  logic        ser  [3];
  logic        busy [3];
  logic [7:0]  cnt  [3];
  logic [31:0] csum [3];
  int unsigned cyc = 0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned CPB = CPB_T[g];
    localparam int unsigned DB  = DB_T[g];
    localparam int unsigned PM  = PM_T[g];
    localparam int unsigned SB  = SB_T[g];
    localparam int unsigned DEP = DEP_T[g];
    localparam int unsigned CW  = $clog2(DEP) + 1;
    localparam int unsigned FL  = (1 + DB + ((PM != 0) ? 1 : 0) + SB) * CPB;

    logic [CW-1:0] cnt_l;
    logic [7:0]    acc_q [$];
    int unsigned   rd_i = 0;
    int unsigned   b2b = 0;

    uart_tx_fifo #(
      .cycles_per_bit(CPB),
      .data_bits     (DB),
      .parity_mode   (PM),
      .stop_bits     (SB),
      .fifo_depth    (DEP)
    ) u_dut (
      .clock     (clk),
      .tock_reset(rst),
      .i_data    (din[g][DB-1:0]),
      .i_valid   (vld[g]),
      .o_ready   (rdy[g]),
      .o_serial  (ser[g]),
      .o_busy    (busy[g]),
      .o_count   (cnt_l),
      .o_checksum(csum[g])
    );

    assign cnt[g] = 8'(cnt_l);

    // Scoreboard push: a word is accepted on an edge with valid and ready.
    always @(posedge clk) begin
      if (!rst && vld[g] && rdy[g]) acc_q.push_back(din[g] & 8'((1 << DB) - 1));
    end

    // Line monitor: on a start bit, pop the expected word and check every cycle.
    initial begin : mon
      logic [7:0]  w;
      logic [15:0] fb;
      int unsigned prev_end;
      bit          seen;
      prev_end = 0;
      seen = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          rd_i = acc_q.size();
        end else if (ser[g] === 1'b0) begin
          chk($sformatf("sb%0d_has_word", g), 64'(acc_q.size() > rd_i), 64'd1);
          w = 8'h00;
          if (acc_q.size() > rd_i) begin
            w = acc_q[rd_i];
            rd_i++;
          end
          if (seen && cyc == prev_end + 1) b2b++;
          fb = '1;
          fb[0] = 1'b0;
          for (int i = 0; i < DB; i++) fb[1 + i] = w[i];
          if (PM != 0) fb[1 + DB] = (^w) ^ (PM == 1);
          for (int c = 0; c < FL; c++) begin
            if (c > 0) @(negedge clk);
            if (rst) begin
              rd_i = acc_q.size();
              break;
            end
            chk($sformatf("ser%0d_w%0h_c%0d", g, w, c), 64'(ser[g]), 64'(fb[c / CPB]));
            if (c < FL - 1) chk($sformatf("busy%0d_w%0h_c%0d", g, w, c), 64'(busy[g]), 64'd1);
          end
          prev_end = cyc;
          seen = 1;
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input int unsigned k, input logic [7:0] w);
    int unsigned n;
    n = 0;
    din[k] = w;
    vld[k] = 1'b1;
    while (!rdy[k] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("push%0d_timeout", k), 64'(n >= 2000), 64'd0);
    @(negedge clk);
    vld[k] = 1'b0;
  endtask

  task automatic busy_len(input int unsigned k, input int unsigned exp_len, input string tag);
    int unsigned n;
    int unsigned t;
    n = 0;
    t = 0;
    while (!busy[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    while (busy[k] && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk(tag, 64'(n), 64'(exp_len));
  endtask

  task automatic wait_idle(input int unsigned k, input string tag);
    int unsigned t;
    t = 0;
    while ((busy[k] || cnt[k] != 8'd0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(t >= 5000), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin : main
    int unsigned n;
    int unsigned idx;
    int unsigned acc;
    int unsigned first_full;
    int unsigned t;
    int unsigned b0;
    logic        r;

    for (int unsigned k = 0; k < 3; k++) begin
      din[k] = 8'h00;
      vld[k] = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    for (int unsigned k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_ser", k),  64'(ser[k]),  64'd1);
      chk($sformatf("rst%0d_busy", k), 64'(busy[k]), 64'd0);
      chk($sformatf("rst%0d_cnt", k),  64'(cnt[k]),  64'd0);
      chk($sformatf("rst%0d_csum", k), 64'(csum[k]), 64'd0);
      chk($sformatf("rst%0d_rdy", k),  64'(rdy[k]),  64'd1);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // 8N1, 0x55: latency and busy length.
    push_word(0, 8'h55);
    chk("lat_cnt1",  64'(cnt[0]),  64'd1);
    chk("lat_ser1",  64'(ser[0]),  64'd1);
    chk("lat_busy1", 64'(busy[0]), 64'd0);
    @(negedge clk);
    chk("lat_cnt2",  64'(cnt[0]),  64'd0);
    chk("lat_busy2", 64'(busy[0]), 64'd1);
    chk("lat_ser2",  64'(ser[0]),  64'd1);
    chk("csum_55",   64'(csum[0]), 64'h55);
    n = 1;
    @(negedge clk);
    chk("lat_ser3", 64'(ser[0]), 64'd0);
    while (busy[0] && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len_8n1", 64'(n), 64'd40);
    wait_idle(0, "idle_8n1");

    // 7E2, 0x13.
    push_word(1, 8'h13);
    busy_len(1, 44, "busy_len_7e2");
    wait_idle(1, "idle_7e2");
    chk("csum_13", 64'(csum[1]), 64'h13);

    // 8O1, 0x00: parity bit must be 1.
    push_word(2, 8'h00);
    busy_len(2, 22, "busy_len_8o1");
    wait_idle(2, "idle_8o1");

    // Flow control: depth 4, valid held with 0x01..0x06.
    reset_pulse();
    b0 = g_dut[0].b2b;
    din[0] = 8'h01;
    vld[0] = 1'b1;
    idx = 1;
    acc = 0;
    first_full = 0;
    t = 0;
    while (idx <= 6 && t < 3000) begin
      r = rdy[0];
      @(negedge clk);
      t++;
      if (r) begin
        acc++;
        if (idx == 6) vld[0] = 1'b0;
        idx++;
        din[0] = 8'(idx);
      end else if (first_full == 0) begin
        first_full = acc;
        chk("flow_full_cnt", 64'(cnt[0]), 64'd4);
      end
    end
    vld[0] = 1'b0;
    chk("flow_timeout", 64'(idx <= 6), 64'd0);
    chk("flow_full_after", 64'(first_full), 64'd5);
    chk("flow_accepts", 64'(acc), 64'd6);
    wait_idle(0, "flow_idle");
    chk("flow_b2b", 64'(g_dut[0].b2b - b0), 64'd5);
    chk("flow_csum", 64'(csum[0]), 64'h15);

    // Push and pop together at count 2 in the last stop cycle (7E2, 44-cycle frames).
    b0 = g_dut[1].b2b;
    push_word(1, 8'h21);
    push_word(1, 8'h42);
    push_word(1, 8'h7F);
    chk("sim_cnt_a", 64'(cnt[1]), 64'd2);
    repeat (42) @(negedge clk);
    chk("sim_cnt_b",  64'(cnt[1]),  64'd2);
    chk("sim_busy_b", 64'(busy[1]), 64'd1);
    din[1] = 8'h05;
    vld[1] = 1'b1;
    @(negedge clk);
    vld[1] = 1'b0;
    chk("sim_cnt_c", 64'(cnt[1]), 64'd2);
    wait_idle(1, "sim_idle");
    chk("sim_b2b", 64'(g_dut[1].b2b - b0), 64'd3);
    chk("sim_csum", 64'(csum[1]), 64'hE7);

    // Reset mid-DATA of 0xA5 with three more words queued.
    push_word(0, 8'hA5);
    push_word(0, 8'h11);
    push_word(0, 8'h22);
    push_word(0, 8'h33);
    repeat (6) @(negedge clk);
    chk("mid_busy", 64'(busy[0]), 64'd1);
    chk("mid_cnt",  64'(cnt[0]),  64'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ser",  64'(ser[0]),  64'd1);
    chk("arst_cnt",  64'(cnt[0]),  64'd0);
    chk("arst_csum", 64'(csum[0]), 64'd0);
    chk("arst_busy", 64'(busy[0]), 64'd0);
    chk("arst_rdy",  64'(rdy[0]),  64'd1);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    push_word(0, 8'h0F);
    busy_len(0, 40, "busy_len_after_rst");
    wait_idle(0, "idle_after_rst");
    chk("csum_after_rst", 64'(csum[0]), 64'h0F);

    // Checksum wrap from a preloaded value.
    force g_dut[2].u_dut.o_checksum = 32'hFFFF_FFF0;
    @(negedge clk);
    release g_dut[2].u_dut.o_checksum;
    @(negedge clk);
    chk("wrap_pre", 64'(csum[2]), 64'hFFFF_FFF0);
    push_word(2, 8'h20);
    @(negedge clk);
    chk("wrap_post", 64'(csum[2]), 64'h10);
    wait_idle(2, "wrap_idle1");
    push_word(2, 8'hFF);
    @(negedge clk);
    chk("wrap_next", 64'(csum[2]), 64'h10F);
    wait_idle(2, "wrap_idle2");

    chk("sb0_left", 64'(g_dut[0].acc_q.size() - g_dut[0].rd_i), 64'd0);
    chk("sb1_left", 64'(g_dut[1].acc_q.size() - g_dut[1].rd_i), 64'd0);
    chk("sb2_left", 64'(g_dut[2].acc_q.size() - g_dut[2].rd_i), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
